// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand muxing, 32-bit ALU with flags, and an enabled result/overflow register
module alu_operand_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] rd1_i,
  input  logic [31:0] rd2_i,
  input  logic [4:0]  shamt_i,
  input  logic [31:0] ext_i,
  input  logic        alu_a_src_i,
  input  logic        alu_b_src_i,
  input  logic [3:0]  alu_op_i,
  input  logic        en_i,
  output logic [31:0] c_o,
  output logic        n_o,
  output logic        z_o,
  output logic        v_o,
  output logic        carry_o,
  output logic [31:0] cq_o,
  output logic        vq_o
);
  logic [31:0] a, b;
  logic [32:0] sum, diff;
  logic [4:0]  sh;
  logic [31:0] cq_d, cq_q = '0;
  logic        vq_d, vq_q = 1'b0;
  assign a    = alu_a_src_i ? {27'b0, shamt_i} : rd1_i;
  assign b    = alu_b_src_i ? ext_i : rd2_i;
  assign sh   = a[4:0];
  assign sum  = {1'b0, a} + {1'b0, b};
  // bit 32 of the 33-bit difference is the unsigned borrow
  assign diff = {1'b0, a} - {1'b0, b};
  always_comb begin
    c_o = '0;
    case (alu_op_i)
      4'd0:  c_o = sum[31:0];
      4'd1:  c_o = diff[31:0];
      4'd2:  c_o = a & b;
      4'd3:  c_o = a | b;
      4'd4:  c_o = a ^ b;
      4'd5:  c_o = ~(a | b);
      4'd6:  c_o = {31'b0, $signed(a) < $signed(b)};
      4'd7:  c_o = {31'b0, a < b};
      4'd8:  c_o = b << sh;
      4'd9:  c_o = b >> sh;
      4'd10: c_o = $unsigned($signed(b) >>> sh);
      4'd11: c_o = {b[15:0], 16'b0};
      default: c_o = '0;
    endcase
  end
  assign v_o = alu_op_i == 4'd0 ? (a[31] == b[31]) && (sum[31] != a[31]) :
               alu_op_i == 4'd1 ? (a[31] != b[31]) && (diff[31] != a[31]) : 1'b0;
  assign carry_o = alu_op_i == 4'd0 ? sum[32] : alu_op_i == 4'd1 ? diff[32] : 1'b0;
  assign n_o = c_o[31];
  assign z_o = c_o == '0;
  assign cq_d = !rst_ni ? '0 : en_i ? c_o : cq_q;
  assign vq_d = !rst_ni ? 1'b0 : en_i ? v_o : vq_q;
  always_ff @(posedge clk_i) begin
    cq_q <= cq_d;
    vq_q <= vq_d;
  end
  assign cq_o = cq_q;
  assign vq_o = vq_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed vectors with hand-computed results for the ALU operand stage
module tb_alu_operand_stage;
  logic        clk = 1'b0;
  logic        rst_n, a_src, b_src, en;
  logic [31:0] rd1, rd2, ext;
  logic [4:0]  shamt;
  logic [3:0]  op;
  logic [31:0] c, cq;
  logic        n, z, v, carry, vq;
  int          n_chk = 0;
  int          n_fail = 0;

  alu_operand_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .rd1_i(rd1), .rd2_i(rd2), .shamt_i(shamt),
    .ext_i(ext), .alu_a_src_i(a_src), .alu_b_src_i(b_src), .alu_op_i(op),
    .en_i(en), .c_o(c), .n_o(n), .z_o(z), .v_o(v), .carry_o(carry),
    .cq_o(cq), .vq_o(vq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; a_src = 1'b0; b_src = 1'b0;
    rd1 = '0; rd2 = '0; ext = '0; shamt = '0; op = '0;
    #1;
    chk("init_cq", cq, 32'h0);
    chk("init_vq", {31'b0, vq}, 32'h0);
    // ADD signed overflow, result still wraps
    rd1 = 32'h7FFF_FFFF; rd2 = 32'h1; op = 4'd0; #1;
    chk("add_c", c, 32'h8000_0000);
    chk("add_v", {31'b0, v}, 32'h1);
    chk("add_n", {31'b0, n}, 32'h1);
    chk("add_z", {31'b0, z}, 32'h0);
    chk("add_carry", {31'b0, carry}, 32'h0);
    // ADD unsigned carry out to zero
    rd1 = 32'hFFFF_FFFF; rd2 = 32'h1; #1;
    chk("addc_c", c, 32'h0);
    chk("addc_carry", {31'b0, carry}, 32'h1);
    chk("addc_z", {31'b0, z}, 32'h1);
    chk("addc_v", {31'b0, v}, 32'h0);
    // SUB borrow, SLT, SLTU
    rd1 = 32'h0; rd2 = 32'h1; op = 4'd1; #1;
    chk("sub_c", c, 32'hFFFF_FFFF);
    chk("sub_carry", {31'b0, carry}, 32'h1);
    chk("sub_v", {31'b0, v}, 32'h0);
    rd1 = 32'h8000_0000; rd2 = 32'h1; #1;
    chk("subov_c", c, 32'h7FFF_FFFF);
    chk("subov_v", {31'b0, v}, 32'h1);
    rd1 = 32'h0; rd2 = 32'h1; op = 4'd6; #1;
    chk("slt_c", c, 32'h1);
    rd1 = 32'hFFFF_FFFF; #1;
    chk("slt_neg_c", c, 32'h1);
    op = 4'd7; #1;
    chk("sltu_c", c, 32'h0);
    chk("sltu_carry", {31'b0, carry}, 32'h0);
    // logic ops
    rd1 = 32'hF0F0_1234; rd2 = 32'h0FF0_FF00; op = 4'd2; #1;
    chk("and_c", c, 32'h00F0_1200);
    op = 4'd5; #1;
    chk("nor_c", c, 32'h000F_00CB);
    // shifts sourced from shamt
    a_src = 1'b1; shamt = 5'd4; rd1 = 32'hFFFF_FFFF; rd2 = 32'h8000_0000; op = 4'd10; #1;
    chk("sra_c", c, 32'hF800_0000);
    chk("sra_v", {31'b0, v}, 32'h0);
    op = 4'd9; #1;
    chk("srl_c", c, 32'h0800_0000);
    op = 4'd8; rd2 = 32'h0000_0003; #1;
    chk("sll_c", c, 32'h0000_0030);
    // register-sourced shift ignores A[31:5]
    a_src = 1'b0; rd1 = 32'hFFFF_FFE4; rd2 = 32'h8000_0000; op = 4'd9; #1;
    chk("srl_hi_ignored", c, 32'h0800_0000);
    // immediate B path
    b_src = 1'b1; ext = 32'h0000_ABCD; op = 4'd11; #1;
    chk("lui_c", c, 32'hABCD_0000);
    chk("lui_n", {31'b0, n}, 32'h1);
    rd1 = 32'h0000_1234; op = 4'd3; #1;
    chk("ori_c", c, 32'h0000_BBFD);
    // zero flag
    b_src = 1'b0; rd1 = 32'h55AA_55AA; rd2 = 32'h55AA_55AA; op = 4'd4; #1;
    chk("xor_c", c, 32'h0);
    chk("xor_z", {31'b0, z}, 32'h1);
    op = 4'd13; #1;
    chk("op13_c", c, 32'h0);
    chk("op13_z", {31'b0, z}, 32'h1);
    chk("op13_v", {31'b0, v}, 32'h0);
    // result register: load, hold, reset
    rst_n = 1'b1; en = 1'b1; rd1 = 32'h7FFF_FFFF; rd2 = 32'h1; op = 4'd0;
    edge_step();
    chk("load_cq", cq, 32'h8000_0000);
    chk("load_vq", {31'b0, vq}, 32'h1);
    en = 1'b0; rd1 = 32'h1; rd2 = 32'h2;
    edge_step();
    chk("hold_cq", cq, 32'h8000_0000);
    chk("hold_vq", {31'b0, vq}, 32'h1);
    chk("hold_c_live", c, 32'h3);
    rst_n = 1'b0; en = 1'b1; #1;
    chk("rst_comb_c", c, 32'h3);
    chk("rst_pre_edge_cq", cq, 32'h8000_0000);
    edge_step();
    chk("rst_cq", cq, 32'h0);
    chk("rst_vq", {31'b0, vq}, 32'h0);
    rst_n = 1'b1; rd1 = 32'h10; rd2 = 32'h20; op = 4'd1;
    edge_step();
    chk("post_rst_cq", cq, 32'hFFFF_FFF0);
    chk("post_rst_vq", {31'b0, vq}, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
